// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: mode codes,
// error flag bit positions and FSM state encoding. The mode codes are the
// same byte values the calculate unit's mode table uses.
package mdu_iter_pkg;

  localparam logic [7:0] MODE_MUL    = 8'h40;
  localparam logic [7:0] MODE_MULH   = 8'h41;
  localparam logic [7:0] MODE_MULHSU = 8'h42;
  localparam logic [7:0] MODE_MULHU  = 8'h43;
  localparam logic [7:0] MODE_DIV    = 8'h44;
  localparam logic [7:0] MODE_DIVU   = 8'h45;
  localparam logic [7:0] MODE_REM    = 8'h46;
  localparam logic [7:0] MODE_REMU   = 8'h47;

  localparam int ERR_DIV0    = 0;
  localparam int ERR_OVF     = 1;
  localparam int ERR_ILLEGAL = 2;
  localparam int ERR_RSVD    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True for the eight 32M mode codes 8'h40..8'h47.
  function automatic logic is_mdu_mode(input logic [7:0] m);
    return (m[7:3] == 5'b01000);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference only
// when it is non-negative. The quotient bit is 1 exactly in that case.
module mdu_div_step (
  input  logic [32:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] diff;

  // Trial subtraction; bit 33 of the difference is the borrow/sign.
  always_comb begin
    diff    = {rem_in, dividend_bit} - {2'b00, divisor};
    q_bit   = ~diff[33];
    rem_out = q_bit ? diff[32:0] : {rem_in[31:0], dividend_bit};
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Handshake: start is accepted only in the IDLE or DONE state (busy=0);
// busy is high for ITER and FIX; done pulses for the single DONE cycle, and
// answer/error are valid from that cycle and held until the next accepted
// start. Optional build macro: MDU_FAST_MUL_EN (single-cycle multiplies).
module mdu_iter
  import mdu_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mode,
  input  logic [31:0] number1,
  input  logic [31:0] number2,
  output logic        busy,
  output logic        done,
  output logic [31:0] answer,
  output logic [3:0]  error
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic        s1_q, s2_q;
  logic [31:0] opnd_q;   // multiplicand |a| or divisor |b|
  logic [63:0] acc_q;    // product accumulator; low half doubles as dividend/quotient
  logic [32:0] rem_q;    // partial remainder
  logic [31:0] answer_q;
  logic [3:0]  error_q;

  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        early;
  logic [31:0] early_ans;
  logic [3:0]  early_err;
  logic [32:0] mul_sum;
  logic [32:0] step_rem;
  logic        step_q;
  logic [63:0] prod;
  logic [31:0] quo, rmd, fix_ans;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  assign busy   = (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign answer = answer_q;
  assign error  = error_q;

  // Operand signedness per mode and the magnitudes that get latched.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (mode)
      MODE_MULH, MODE_DIV, MODE_REM: begin
        sa = number1[31];
        sb = number2[31];
      end
      MODE_MULHSU: sa = number1[31];
      default: ;
    endcase
    mag_a = sa ? (32'd0 - number1) : number1;
    mag_b = sb ? (32'd0 - number2) : number2;
  end

  // Early-out detection: cases resolved at the start edge without iterating.
  always_comb begin
    early     = 1'b0;
    early_ans = '0;
    early_err = '0;
`ifdef MDU_FAST_MUL_EN
    fast_prod = {{32{sa}}, number1} * {{32{sb}}, number2};
`endif
    if (!is_mdu_mode(mode)) begin
      early                  = 1'b1;
      early_err[ERR_ILLEGAL] = 1'b1;
    end else if (mode[2] && (number2 == 32'd0)) begin
      early               = 1'b1;
      early_err[ERR_DIV0] = 1'b1;
      early_ans           = mode[1] ? number1 : 32'hFFFF_FFFF;
    end else if (((mode == MODE_DIV) || (mode == MODE_REM)) &&
                 (number1 == 32'h8000_0000) && (number2 == 32'hFFFF_FFFF)) begin
      early              = 1'b1;
      early_err[ERR_OVF] = 1'b1;
      early_ans          = mode[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MDU_FAST_MUL_EN
    else if (!mode[2]) begin
      early     = 1'b1;
      early_ans = (mode[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  // Next-state logic; a start in DONE behaves exactly like one in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = early ? ST_DONE : ST_ITER;
        else       state_d = ST_IDLE;
      end
      ST_ITER: if (cnt_q == 5'd31) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  end

  mdu_div_step u_div_step (
    .rem_in       (rem_q),
    .dividend_bit (acc_q[31]),
    .divisor      (opnd_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Sign correction and result select for the FIX state.
  always_comb begin
    fix_ans = '0;
    prod    = (s1_q ^ s2_q) ? (64'd0 - acc_q) : acc_q;
    quo     = (s1_q ^ s2_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rmd     = s1_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    case (op_q)
      3'b000:                 fix_ans = prod[31:0];
      3'b001, 3'b010, 3'b011: fix_ans = prod[63:32];
      3'b100, 3'b101:         fix_ans = quo;
      default:                fix_ans = rmd;
    endcase
  end

  // Datapath: operand latch on accept, one iteration per ITER cycle,
  // result registers written only on early-out or FIX->DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      answer_q <= '0;
      error_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cnt_q <= '0;
            op_q  <= mode[2:0];
            s1_q  <= sa;
            s2_q  <= sb;
            rem_q <= '0;
            if (early) begin
              answer_q <= early_ans;
              error_q  <= early_err;
            end else if (mode[2]) begin
              opnd_q <= mag_b;
              acc_q  <= {32'd0, mag_a};
            end else begin
              opnd_q <= mag_a;
              acc_q  <= {32'd0, mag_b};
            end
          end
        end
        ST_ITER: begin
          cnt_q <= cnt_q + 5'd1;
          if (op_q[2]) begin
            rem_q       <= step_rem;
            acc_q[31:0] <= {acc_q[30:0], step_q};
          end else begin
            acc_q <= {mul_sum, acc_q[31:1]};
          end
        end
        ST_FIX: begin
          answer_q <= fix_ans;
          error_q  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: directed RV32M cases, early-outs, busy-start
// rejection, mid-operation reset and a short randomized run against a
// behavioural reference model.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mode;
  logic [31:0] number1;
  logic [31:0] number2;
  logic        busy;
  logic        done;
  logic [31:0] answer;
  logic [3:0]  error;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  err_q[$];
  int          lat_q[$];

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  mdu_iter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .number1 (number1),
    .number2 (number2),
    .busy    (busy),
    .done    (done),
    .answer  (answer),
    .error   (error)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected cycles from the start edge to done (1 = early-out, 34 = iterative).
  function automatic int exp_lat(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m[7:3] != 5'b01000) return 1;
    if (!m[2]) return FAST ? 1 : 34;
    if (b == 32'd0) return 1;
    if (((m == MODE_DIV) || (m == MODE_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Reference answer from plain SV arithmetic.
  function automatic logic [31:0] ref_ans(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (m)
      MODE_MUL, MODE_MULH: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MODE_MULHSU:         p = {{32{a[31]}}, a} * {32'd0, b};
      MODE_MULHU:          p = {32'd0, a} * {32'd0, b};
      default: ;
    endcase
    case (m)
      MODE_MUL:                       return p[31:0];
      MODE_MULH, MODE_MULHSU, MODE_MULHU: return p[63:32];
      MODE_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      MODE_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MODE_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      MODE_REMU: return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_err(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m[7:3] != 5'b01000) return 4'b0100;
    if (m[2] && (b == 0)) return 4'b0001;
    if (((m == MODE_DIV) || (m == MODE_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 4'b0010;
    return 4'b0000;
  endfunction

  // Driver: push expectations, issue one start, optionally poke start
  // again while busy, wait (bounded) for done and check against the queues.
  task automatic run_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_ans, input logic [3:0] e_err,
                        input string tag, input int inject_at);
    int cyc;
    int e_lat;
    exp_q.push_back(e_ans);
    err_q.push_back(e_err);
    lat_q.push_back(exp_lat(m, a, b));
    @(negedge clk);
    start = 1'b1; mode = m; number1 = a; number2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    e_lat = lat_q.pop_front();
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (e_lat != 1)});
    while ((done !== 1'b1) && (cyc < 60)) begin
      if (cyc == inject_at) begin
        start = 1'b1; mode = MODE_MUL; number1 = 32'h3; number2 = 32'h5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(e_lat));
    chk({tag, "_answer"}, answer, exp_q.pop_front());
    chk({tag, "_error"}, {28'd0, error}, {28'd0, err_q.pop_front()});
  endtask

  task automatic run_ref(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b, input string tag);
    run_op(m, a, b, ref_ans(m, a, b), ref_err(m, a, b), tag, 0);
  endtask

  initial begin
    int ndone;
    logic [7:0]  rm;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; mode = '0; number1 = '0; number2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_answer", answer, 32'd0);
    chk("rst_error",  {28'd0, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiplies on all-ones operands.
    run_op(MODE_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, "mul_ff", 0);
    run_op(MODE_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, "mulh_ff", 0);
    run_op(MODE_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0000, "mulhu_ff", 0);
    run_op(MODE_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, "mulhsu_ff", 0);

    // Divides with signed correction.
    run_op(MODE_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b0000, "div_m7_2", 0);
    run_op(MODE_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b0000, "rem_m7_2", 0);
    run_op(MODE_DIVU, 32'd100, 32'd7, 32'd14, 4'b0000, "divu_100_7", 0);
    run_op(MODE_REMU, 32'd100, 32'd7, 32'd2,  4'b0000, "remu_100_7", 0);

    // Early-out paths.
    run_op(MODE_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'b0001, "divu_by0", 0);
    run_op(MODE_REMU, 32'd7, 32'd0, 32'd7,         4'b0001, "remu_by0", 0);
    run_op(MODE_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         4'b0010, "rem_ovf", 0);
    run_op(MODE_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0010, "div_ovf", 0);
    run_op(8'h48,     32'd5, 32'd3, 32'd0, 4'b0100, "illegal", 0);

    // A start while busy with other operands must be ignored.
    run_op(MODE_DIVU, 32'd100, 32'd7, 32'd14, 4'b0000, "busy_start", 5);

    // Reset at ITER count 10 abandons the operation.
    run_op(MODE_REMU, 32'd100, 32'd7, 32'd2, 4'b0000, "pre_rst", 0);
    @(negedge clk);
    start = 1'b1; mode = MODE_DIV; number1 = 32'hFFFF_FFF9; number2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_done",   {31'd0, done}, 32'd0);
    chk("midrst_answer", answer, 32'd0);
    chk("midrst_error",  {28'd0, error}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      rm = MODE_MUL + 8'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_ref(rm, ra, rb, $sformatf("rand%0d_m%h", i, rm));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
